matmul_stream_core: RTL and testbench
=====================================

// Module: matmul_stream_core
// PURPOSE
//   Parametrised streaming matrix-multiply core: Lanes parallel signed MAC lanes, each reducing
//   a tile of cfg_len operand beats into one partial sum. Adds valid/ready handshakes on both
//   sides, runtime tile depth, and a one-deep result register so the next tile accumulates
//   while the previous result drains. Sits between the ifmap/filter buffers and the psum writeback.
// PARAMETERS
//   Lanes     4   number of parallel MAC lanes
//   DataWidth 8   signed operand width; ifmap and filter are both this width
//   PsumWidth 16  signed accumulator/result width; must be >= 2*DataWidth
//   MaxDepth  64  maximum beats per tile; LenW = $clog2(MaxDepth)+1
// PORTS
//   clk        in   1                 clock; all state updates on posedge
//   rst        in   1                 reset, synchronous, active-high
//   cfg_len    in   LenW              beats per tile; sampled on the first beat of each tile
//   in_valid   in   1                 operand beat valid
//   in_ready   out  1                 core can accept a beat
//   in_ifmap   in   Lanes*DataWidth   lane i operand at [i*DataWidth +: DataWidth]
//   in_filter  in   Lanes*DataWidth   lane i weight, same packing
//   out_valid  out  1                 result vector valid
//   out_ready  in   1                 downstream accepts result
//   out_psum   out  Lanes*PsumWidth   lane i result at [i*PsumWidth +: PsumWidth]
//   out_sat    out  Lanes             per-lane saturation flag for the held result
//   busy       out  1                 tile in progress, or a result is held or pending
// BEHAVIOUR
//   Reset: out_valid=0, out_psum=0, out_sat=0, busy=0, in_ready=1, beat counter=0, FSM=IDLE.
//   Beat transfer: in_valid && in_ready on a posedge. Result transfer: out_valid && out_ready.
//   FSM states:
//     IDLE  no beat of the current tile has been taken.
//           On a beat: latch len = (cfg_len==0 ? 1 : min(cfg_len,MaxDepth)), and acc = product.
//           If len==1 the beat is also the final beat. Otherwise go to ACC.
//     ACC   each beat does acc += product and cnt++. The beat with cnt==len-1 is the final beat.
//     STALL entered when a final beat completes while the result register is occupied and
//           not draining this cycle. in_ready=0; acc holds the finished tile. When out_ready
//           is seen, acc moves to out_psum on that edge and the FSM returns to IDLE.
//   Final beat with result register free, or draining that same cycle:
//     - out_psum = acc + product; out_valid=1 on the next cycle (latency 1 after the last beat).
//     - FSM goes to IDLE, so back-to-back tiles run with no bubble.
//   in_ready = (state != STALL).
//   out_valid stays high and out_psum/out_sat stay stable until accepted.
//   cfg_len changes in the middle of a tile are ignored.
//   Arithmetic:
//     - product = signed DataWidth x signed DataWidth -> 2*DataWidth bits, sign-extended to PsumWidth.
//     - Without the macro, accumulation wraps mod 2^PsumWidth.
//   Reset mid-tile or during STALL: the partial tile and the held result are discarded;
//   the state is identical to post-reset.
// CONFIGURATION
//   MATMUL_SAT_EN defined:
//     - Each add clamps to [-2^(PsumWidth-1), 2^(PsumWidth-1)-1].
//     - The lane sat flag is sticky across the tile and is copied to out_sat with the result.
//   MATMUL_SAT_EN undefined: wrap-around arithmetic; out_sat tied to 0.
// STRUCTURE
//   Package matmul_pkg holds:
//     - FSM state enum (IDLE, ACC, STALL)
//     - Signed product/extend helper function
//     - Saturating add function, parametrised by width via localparams
//   Sub-module mac_lane: one lane's multiply, sign-extend, accumulate and saturate logic;
//   generated Lanes times. The core holds the FSM, beat counter, len latch and result register.
// TESTING (Lanes=4, DataWidth=8, PsumWidth=16)
//   Reset -> out_valid=0, in_ready=1, busy=0, out_psum=0.
//   cfg_len=3, lane0 beats (2,3),(4,5),(-1,6) -> lane0 out_psum=20; out_valid one cycle after beat 3.
//   out_ready=0, two cfg_len=1 tiles of (1,1) then (2,2):
//     - out_psum=1 is held; in_ready=0 after the 2nd beat.
//     - Raise out_ready -> results 1 then 4, in order; in_ready returns to 1.
//   cfg_len=4, all beats (127,127):
//     - Without MATMUL_SAT_EN -> 0xFC04 (-1020), out_sat=0.
//     - With MATMUL_SAT_EN -> 32767, out_sat=1.
//   cfg_len=0, one beat (-128,-128) -> out_psum=16384 after the single beat.
//   cfg_len=3, rst after 2 beats, then a fresh cfg_len=1 tile (3,3) -> out_psum=9, with no stale data.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and arithmetic helpers for the streaming matmul core.
// Helpers work on a 64-bit signed intermediate so any PsumWidth up to 63 fits.
package matmul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_STALL
  } state_e;

  localparam int EXT_W = 64;

  typedef struct packed {
    logic                    sat;
    logic signed [EXT_W-1:0] sum;
  } sat_res_t;

  function automatic logic signed [EXT_W-1:0] ext_prod(input logic signed [31:0] a,
                                                       input logic signed [31:0] b);
    logic signed [EXT_W-1:0] a_x;
    logic signed [EXT_W-1:0] b_x;
    a_x = EXT_W'(a);
    b_x = EXT_W'(b);
    return a_x * b_x;
  endfunction

  // Clamp a + b to the signed range of a w-bit accumulator.
  function automatic sat_res_t sat_add(input logic signed [EXT_W-1:0] a,
                                       input logic signed [EXT_W-1:0] b,
                                       input int w);
    logic signed [EXT_W:0] s;
    logic signed [EXT_W:0] hi;
    logic signed [EXT_W:0] lo;
    sat_res_t r;
    s  = (EXT_W+1)'(a) + (EXT_W+1)'(b);
    hi = {{EXT_W{1'b0}}, 1'b1};
    hi = (hi <<< (w - 1)) - {{EXT_W{1'b0}}, 1'b1};
    lo = ~hi;
    r.sat = 1'b0;
    r.sum = s[EXT_W-1:0];
    if (s > hi) begin
      r.sat = 1'b1;
      r.sum = hi[EXT_W-1:0];
    end else if (s < lo) begin
      r.sat = 1'b1;
      r.sum = lo[EXT_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/matmul_stream_core_if.sv
// Operand and result handshake bundle for matmul_stream_core.
// master = producer/consumer side, slave = the core.
interface matmul_stream_core_if #(
  parameter int Lanes     = 4,
  parameter int DataWidth = 8,
  parameter int PsumWidth = 16
);
  logic                       in_valid;
  logic                       in_ready;
  logic [Lanes*DataWidth-1:0] in_ifmap;
  logic [Lanes*DataWidth-1:0] in_filter;
  logic                       out_valid;
  logic                       out_ready;
  logic [Lanes*PsumWidth-1:0] out_psum;
  logic [Lanes-1:0]           out_sat;

  modport master (
    output in_valid, in_ifmap, in_filter, out_ready,
    input  in_ready, out_valid, out_psum, out_sat
  );

  modport slave (
    input  in_valid, in_ifmap, in_filter, out_ready,
    output in_ready, out_valid, out_psum, out_sat
  );
endinterface

// File: rtl/matmul_stream_core_mac_lane.sv
// One MAC lane: signed multiply, sign-extend, accumulate.
// MATMUL_SAT_EN selects clamping adds with a sticky per-tile flag; otherwise wrap.
module mac_lane
  import matmul_pkg::*;
#(
  parameter int DataWidth = 8,
  parameter int PsumWidth = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        beat_i,
  input  logic                        first_i,
  input  logic signed [DataWidth-1:0] ifmap_i,
  input  logic signed [DataWidth-1:0] filter_i,
  output logic signed [PsumWidth-1:0] acc_o,
  output logic                        sat_o,
  output logic signed [PsumWidth-1:0] sum_o,
  output logic                        sum_sat_o
);
  logic signed [31:0]          a_ext;
  logic signed [31:0]          b_ext;
  logic signed [PsumWidth-1:0] prod;
  logic signed [PsumWidth-1:0] acc_q;
  logic                        sat_q;
`ifdef MATMUL_SAT_EN
  sat_res_t                    r;
`endif

  assign a_ext = 32'(ifmap_i);
  assign b_ext = 32'(filter_i);

  // sum_o is what the accumulator becomes if this cycle's beat is taken.
  always_comb begin
    prod      = PsumWidth'(ext_prod(a_ext, b_ext));
    sum_o     = prod;
    sum_sat_o = 1'b0;
`ifdef MATMUL_SAT_EN
    r = '0;
    if (!first_i) begin
      r         = sat_add(EXT_W'(acc_q), EXT_W'(prod), PsumWidth);
      sum_o     = PsumWidth'(r.sum);
      sum_sat_o = sat_q | r.sat;
    end
`else
    if (!first_i) sum_o = acc_q + prod;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else if (beat_i) begin
      acc_q <= sum_o;
      sat_q <= sum_sat_o;
    end
  end

  assign acc_o = acc_q;
  assign sat_o = sat_q;
endmodule

// File: rtl/matmul_stream_core.sv
// Streaming matmul core: Lanes MAC lanes, tile FSM, one-deep result register.
// Optional saturation via MATMUL_SAT_EN (handled inside mac_lane).
module matmul_stream_core
  import matmul_pkg::*;
#(
  parameter int  Lanes     = 4,
  parameter int  DataWidth = 8,
  parameter int  PsumWidth = 16,
  parameter int  MaxDepth  = 64,
  localparam int LenW      = $clog2(MaxDepth) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LenW-1:0]  cfg_len,
  output logic             busy,
  matmul_stream_core_if.slave bus
);
  state_e                     state_q, state_d;
  logic [LenW-1:0]            len_q, len_d;
  logic [LenW-1:0]            cnt_q, cnt_d;
  logic [LenW-1:0]            eff_len;
  logic                       out_valid_q;
  logic [Lanes*PsumWidth-1:0] psum_q;
  logic [Lanes-1:0]           sat_q;
  logic                       fire, last, res_free, load_sum, load_acc;
  logic [Lanes*PsumWidth-1:0] sum_vec, acc_vec;
  logic [Lanes-1:0]           sum_sat_vec, acc_sat_vec;

  for (genvar i = 0; i < Lanes; i++) begin : g_lane
    mac_lane #(.DataWidth(DataWidth), .PsumWidth(PsumWidth)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .beat_i   (fire),
      .first_i  (state_q == ST_IDLE),
      .ifmap_i  (bus.in_ifmap[i*DataWidth +: DataWidth]),
      .filter_i (bus.in_filter[i*DataWidth +: DataWidth]),
      .acc_o    (acc_vec[i*PsumWidth +: PsumWidth]),
      .sat_o    (acc_sat_vec[i]),
      .sum_o    (sum_vec[i*PsumWidth +: PsumWidth]),
      .sum_sat_o(sum_sat_vec[i])
    );
  end

  always_comb begin
    eff_len = cfg_len;
    if (cfg_len == '0) eff_len = LenW'(1);
    else if (cfg_len > LenW'(MaxDepth)) eff_len = LenW'(MaxDepth);
  end

  assign bus.in_ready = (state_q != ST_STALL);
  assign fire     = bus.in_valid && bus.in_ready;
  assign res_free = !out_valid_q || bus.out_ready;
  assign last     = fire && (((state_q == ST_IDLE) && (eff_len == LenW'(1))) ||
                             ((state_q == ST_ACC) && (cnt_q == len_q - LenW'(1))));

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    load_sum = 1'b0;
    load_acc = 1'b0;
    case (state_q)
      ST_IDLE, ST_ACC: begin
        if (fire) begin
          if (state_q == ST_IDLE) len_d = eff_len;
          if (last) begin
            cnt_d = '0;
            if (res_free) begin
              load_sum = 1'b1;
              state_d  = ST_IDLE;
            end else begin
              state_d = ST_STALL;
            end
          end else begin
            cnt_d   = (state_q == ST_IDLE) ? LenW'(1) : cnt_q + LenW'(1);
            state_d = ST_ACC;
          end
        end
      end
      ST_STALL: begin
        // Result register is full here, so out_ready means it drains this edge.
        if (bus.out_ready) begin
          load_acc = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      psum_q      <= '0;
      sat_q       <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      if (load_sum) begin
        psum_q      <= sum_vec;
        sat_q       <= sum_sat_vec;
        out_valid_q <= 1'b1;
      end else if (load_acc) begin
        psum_q      <= acc_vec;
        sat_q       <= acc_sat_vec;
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_psum  = psum_q;
  assign bus.out_sat   = sat_q;
  assign busy          = (state_q != ST_IDLE) || out_valid_q;
endmodule

// File: tb/tb_matmul_stream_core.sv
// Directed bench for matmul_stream_core (Lanes=4, DataWidth=8, PsumWidth=16).
module tb_matmul_stream_core;
  localparam int Lanes = 4;
  localparam int DW    = 8;
  localparam int PW    = 16;
  localparam int LenW  = 7;

  logic            clk = 1'b0;
  logic            rst;
  logic [LenW-1:0] cfg_len;
  logic            busy;
  int              checks = 0;
  int              errors = 0;

  matmul_stream_core_if #(.Lanes(Lanes), .DataWidth(DW), .PsumWidth(PW)) bus();

  matmul_stream_core #(.Lanes(Lanes), .DataWidth(DW), .PsumWidth(PW), .MaxDepth(64)) dut (
    .clk    (clk),
    .rst    (rst),
    .cfg_len(cfg_len),
    .busy   (busy),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] a, input logic [7:0] b, input bit all_lanes);
    bus.in_valid  = 1'b1;
    bus.in_ifmap  = all_lanes ? {4{a}} : {24'h0, a};
    bus.in_filter = all_lanes ? {4{b}} : {24'h0, b};
    step();
    bus.in_valid  = 1'b0;
    bus.in_ifmap  = '0;
    bus.in_filter = '0;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_len = '0;
    bus.in_valid = 1'b0; bus.in_ifmap = '0; bus.in_filter = '0; bus.out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (bus.out_psum !== 64'h0) begin errors++; $display("FAIL reset_psum got %h want 0", bus.out_psum); end
    checks++; if (bus.out_sat !== 4'h0) begin errors++; $display("FAIL reset_sat got %h want 0", bus.out_sat); end
  endtask

  // Tile of 3; cfg_len is changed mid-tile and must be ignored.
  task automatic test_basic();
    cfg_len = 7'd3;
    beat(8'd2, 8'd3, 1'b0);
    cfg_len = 7'd1;
    beat(8'd4, 8'd5, 1'b0);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", bus.out_valid); end
    beat(8'hFF, 8'd6, 1'b0);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", bus.out_valid); end
    checks++; if (bus.out_psum !== {48'h0, 16'd20}) begin errors++; $display("FAIL basic_psum got %h want %h", bus.out_psum, {48'h0, 16'd20}); end
    step();
    checks++; if (bus.out_psum[15:0] !== 16'd20 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_hold got %h/%b want 0014/1", bus.out_psum[15:0], bus.out_valid); end
    drain();
    checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_drain got valid %b busy %b want 0 0", bus.out_valid, busy); end
  endtask

  task automatic test_stall();
    cfg_len = 7'd1;
    beat(8'd1, 8'd1, 1'b0);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_psum[15:0] !== 16'd1) begin errors++; $display("FAIL stall_first got %b/%h want 1/0001", bus.out_valid, bus.out_psum[15:0]); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready1 got %b want 1", bus.in_ready); end
    beat(8'd2, 8'd2, 1'b0);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready0 got %b want 0", bus.in_ready); end
    checks++; if (bus.out_psum[15:0] !== 16'd1 || busy !== 1'b1) begin errors++; $display("FAIL stall_held got %h busy %b want 0001 1", bus.out_psum[15:0], busy); end
    bus.out_ready = 1'b1;
    step();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_psum[15:0] !== 16'd4) begin errors++; $display("FAIL stall_second got %b/%h want 1/0004", bus.out_valid, bus.out_psum[15:0]); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_back got %b want 1", bus.in_ready); end
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_drained got %b want 0", bus.out_valid); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    cfg_len = 7'd2;
    beat(8'd1, 8'd1, 1'b0);
    beat(8'd1, 8'd1, 1'b0);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_psum[15:0] !== 16'd2) begin errors++; $display("FAIL b2b_first got %b/%h want 1/0002", bus.out_valid, bus.out_psum[15:0]); end
    beat(8'd2, 8'd2, 1'b0);
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_mid got valid %b ready %b want 0 1", bus.out_valid, bus.in_ready); end
    beat(8'd2, 8'd2, 1'b0);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_psum[15:0] !== 16'd8) begin errors++; $display("FAIL b2b_second got %b/%h want 1/0008", bus.out_valid, bus.out_psum[15:0]); end
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_saturation();
    logic [15:0] exp_lane;
    logic [3:0]  exp_sat;
`ifdef MATMUL_SAT_EN
    exp_lane = 16'h7FFF; exp_sat = 4'hF;
`else
    exp_lane = 16'hFC04; exp_sat = 4'h0;
`endif
    cfg_len = 7'd4;
    for (int i = 0; i < 4; i++) beat(8'd127, 8'd127, 1'b1);
    checks++; if (bus.out_psum !== {4{exp_lane}}) begin errors++; $display("FAIL sat_psum got %h want %h", bus.out_psum, {4{exp_lane}}); end
    checks++; if (bus.out_sat !== exp_sat) begin errors++; $display("FAIL sat_flag got %h want %h", bus.out_sat, exp_sat); end
    drain();
  endtask

  task automatic test_len_zero();
    cfg_len = 7'd0;
    beat(8'h80, 8'h80, 1'b0);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_psum !== {48'h0, 16'h4000}) begin errors++; $display("FAIL len0 got %b/%h want 1/%h", bus.out_valid, bus.out_psum, {48'h0, 16'h4000}); end
    drain();
  endtask

  task automatic test_max_depth();
    cfg_len = 7'd100;
    for (int i = 0; i < 63; i++) beat(8'd1, 8'd1, 1'b0);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL maxdepth_early got %b want 0", bus.out_valid); end
    beat(8'd1, 8'd1, 1'b0);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_psum[15:0] !== 16'd64) begin errors++; $display("FAIL maxdepth got %b/%h want 1/0040", bus.out_valid, bus.out_psum[15:0]); end
    drain();
  endtask

  task automatic test_reset_mid();
    cfg_len = 7'd3;
    beat(8'd5, 8'd5, 1'b0);
    beat(8'd5, 8'd5, 1'b0);
    rst = 1'b1; step(); rst = 1'b0;
    checks++; if (busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_state got busy %b ready %b valid %b want 0 1 0", busy, bus.in_ready, bus.out_valid); end
    cfg_len = 7'd1;
    beat(8'd3, 8'd3, 1'b0);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_psum !== {48'h0, 16'd9}) begin errors++; $display("FAIL rstmid_fresh got %b/%h want 1/%h", bus.out_valid, bus.out_psum, {48'h0, 16'd9}); end
    beat(8'd1, 8'd1, 1'b0);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rststall_enter got %b want 0", bus.in_ready); end
    rst = 1'b1; step(); rst = 1'b0;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_psum !== 64'h0) begin errors++; $display("FAIL rststall got ready %b valid %b psum %h want 1 0 0", bus.in_ready, bus.out_valid, bus.out_psum); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_saturation();
    test_len_zero();
    test_max_depth();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
